// File: rtl/sn74_ls374_pkg.sv
// Shared constants for the sn74_ls374 octal D register with tri-state outputs.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
package sn74_ls374_pkg;

   // Default register width, plus the widest width the block supports.
   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned MAX_WIDTH     = 32;

   // Value every register bit takes while rst_n is low.
   localparam logic [MAX_WIDTH-1:0] RESET_VALUE = '0;

   // Output enable is active-low. Only a definite 0 turns the drivers on.
   // X or Z on the enable is treated as "not enabled", so the outputs float.
   function automatic logic out_enabled(input logic oe_n);
      return (oe_n === 1'b0);
   endfunction

endpackage : sn74_ls374_pkg

// File: rtl/sn74_ls374_bit.sv
// One register slice: a D flop with asynchronous clear, followed by an active-low tri-state driver.
// Latency: the flop output updates at the capturing rising edge; the driver is combinational.
// Backpressure: none. The flop loads on every rising edge, and oe_n gates only the driver.
module sn74_ls374_bit
   import sn74_ls374_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   input  logic oe_n,
   output logic q,
   output logic y
);

   logic q_q;
   logic q_d;

   // Next-state value: there is no load enable, so each edge captures the D input.
   always_comb begin
      q_d = d;
   end

   // Storage flop. The asynchronous clear overrides the clock, and clock edges
   // are ignored while the clear is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   // Register readback. This output is always driven.
   assign q = q_q;

   // Pin driver. Only oe_n decides whether the pin floats; reset does not affect it.
   assign y = out_enabled(oe_n) ? q_q : 1'bz;

endmodule : sn74_ls374_bit

// File: rtl/sn74_ls374.sv
// WIDTH-bit edge-triggered D register with tri-state outputs. Optional q_rb readback port under SN74_LS374_READBACK_EN.
// Latency: q loads at each rising clk edge. out follows q and out_control combinationally.
// Backpressure: none. The register captures on every edge, whether or not the outputs are floating.
module sn74_ls374
   import sn74_ls374_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data,
   input  logic             out_control,
`ifdef SN74_LS374_READBACK_EN
   output logic [WIDTH-1:0] q_rb,
`endif
   output logic [WIDTH-1:0] out
);

   // Reject unsupported widths when the design is elaborated.
   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
      $error("sn74_ls374: WIDTH must be in 1..%0d", MAX_WIDTH);
   end

   // Internal register value gathered from the slices.
   logic [WIDTH-1:0] q_vec;

   // One slice per bit. Each slice has its own flop and its own tri-state driver,
   // so every bit shares the same timing and no shared output mux is needed.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sn74_ls374_bit #(
         .RST_VAL (RESET_VALUE[i])
      ) u_bit (
         .clk  (clk),
         .rst_n(rst_n),
         .d    (data[i]),
         .oe_n (out_control),
         .q    (q_vec[i]),
         .y    (out[i])
      );
   end

`ifdef SN74_LS374_READBACK_EN
   // Readback is the raw register value. It does not depend on out_control.
   assign q_rb = q_vec;
`else
   // Without the readback port the internal register has no other consumer.
   logic unused_q_vec;
   assign unused_q_vec = ^q_vec;
`endif

endmodule : sn74_ls374

// File: tb/tb_sn74_ls374.sv
// Directed bench for sn74_ls374 with WIDTH=8.
// A floating out reads as 8'hFF through pullups, so float checks use register values other than 8'hFF.
// Inputs are driven 1 time unit after edges; outputs are sampled 1 time unit after changes.
module tb_sn74_ls374;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] data;
   logic         out_control;
   wire  [W-1:0] out_w;
`ifdef SN74_LS374_READBACK_EN
   wire  [W-1:0] q_rb_w;
`endif

   int checks   = 0;
   int failures = 0;

   // Weak pullups make a released bus observable as all ones.
   for (genvar g = 0; g < W; g++) begin : g_pu
      pullup (out_w[g]);
   end

   always #5 clk = ~clk;

   sn74_ls374 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data),
      .out_control(out_control),
`ifdef SN74_LS374_READBACK_EN
      .q_rb       (q_rb_w),
`endif
      .out        (out_w)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Wait for the next rising edge, then step 1 time unit past it.
   task automatic rise();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset asserted, outputs disabled: the bus floats.
      rst_n       = 1'b0;
      out_control = 1'b1;
      data        = 8'hAA;
      #3;
      chk("reset_float", out_w, 8'hFF);
      out_control = 1'b0;
      #1;
      chk("reset_drive", out_w, 8'h00);
      // Clock edges are ignored while reset is held.
      rise();
      rise();
      chk("reset_ignores_clk", out_w, 8'h00);

      // Capture while floating, then enable the outputs with no clock edge.
      rst_n       = 1'b1;
      out_control = 1'b1;
      data        = 8'h01;
      rise();
      chk("capture_while_float", out_w, 8'hFF);
      #2;
      out_control = 1'b0;
      #1;
      chk("enable_shows_last", out_w, 8'h01);

      // Counting pattern 00..FF, then the wrap back to 00.
      for (int i = 0; i <= 256; i++) begin
         data = i[7:0];
         rise();
         chk("count", out_w, i[7:0]);
      end

      // Data changes between edges and across a falling edge leave out unchanged.
      data = 8'hA5;
      rise();
      chk("capture_a5", out_w, 8'hA5);
      data = 8'h5A;
      #1;
      chk("hold_mid_cycle", out_w, 8'hA5);
      @(negedge clk);
      #1;
      chk("hold_after_negedge", out_w, 8'hA5);
      rise();
      chk("capture_5a", out_w, 8'h5A);
      // Reloading the same value keeps out stable.
      rise();
      chk("reload_same", out_w, 8'h5A);

      // out_control falls at the same time as the rising edge: out shows the new value.
      out_control = 1'b1;
      data        = 8'h77;
      @(posedge clk);
      out_control = 1'b0;
      #1;
      chk("simul_edge_enable", out_w, 8'h77);

      // Asynchronous clear in the middle of a cycle.
      data = 8'h3C;
      rise();
      chk("capture_3c", out_w, 8'h3C);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_clear", out_w, 8'h00);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      data  = 8'h12;
      #1;
      chk("still_clear_after_release", out_w, 8'h00);
      rise();
      chk("first_edge_after_reset", out_w, 8'h12);

      // The register keeps capturing while the outputs float.
      out_control = 1'b1;
      data        = 8'hC3;
      rise();
      chk("float_c3", out_w, 8'hFF);
`ifdef SN74_LS374_READBACK_EN
      chk("q_rb_c3", q_rb_w, 8'hC3);
`endif
      out_control = 1'b0;
      #1;
      chk("enable_c3", out_w, 8'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sn74_ls374
